// File: rtl/mips_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_defs (package)
// Description : Shared encodings for the multicycle MIPS control path:
//               opcode/funct constants, extender / ALU / PC-source select
//               encodings, FSM state codes and the decoded instruction class.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_defs;

    // Opcodes (IR[31:26])
    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_ori   = 6'h0D;
    localparam logic [5:0] c_op_lui   = 6'h0F;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] c_fn_addu  = 6'h21;
    localparam logic [5:0] c_fn_subu  = 6'h23;

    // Immediate extender control
    localparam logic [1:0] c_ext_zero = 2'b00;
    localparam logic [1:0] c_ext_sign = 2'b01;
    localparam logic [1:0] c_ext_lui  = 2'b10;
    localparam logic [1:0] c_ext_none = 2'b11;

    // ALU operation
    localparam logic [1:0] c_alu_add  = 2'b00;
    localparam logic [1:0] c_alu_sub  = 2'b01;
    localparam logic [1:0] c_alu_or   = 2'b10;
    localparam logic [1:0] c_alu_pass = 2'b11;

    // Next-PC source
    localparam logic [1:0] c_pc_plus4  = 2'b00;
    localparam logic [1:0] c_pc_branch = 2'b01;
    localparam logic [1:0] c_pc_jump   = 2'b10;

    // FSM state codes; 5..7 are unused and recover to FETCH
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    // Decoded instruction class
    typedef enum logic [3:0] {
        C_ILLEGAL = 4'd0,
        C_ADDU    = 4'd1,
        C_SUBU    = 4'd2,
        C_ORI     = 4'd3,
        C_LUI     = 4'd4,
        C_LW      = 4'd5,
        C_SW      = 4'd6,
        C_BEQ     = 4'd7,
        C_J       = 4'd8
    } instr_cls_t;

endpackage : mips_defs
`default_nettype wire

// File: rtl/mips_mc_decode.sv
`default_nettype none
// ============================================================================
// Module      : mips_mc_decode
// Description : Combinational instruction decoder. Maps opcode/funct to an
//               instruction class, the immediate-extender control and an
//               illegal-instruction flag.
// Ports       : i_opcode  [5:0] IR[31:26]
//               i_funct   [5:0] IR[5:0]
//               o_cls           decoded instruction class
//               o_ext_op  [1:0] extender control (depends on opcode only)
//               o_illegal       unsupported opcode/funct combination
// Revision    : 1.0 - initial release
// ============================================================================
module mips_mc_decode
    import mips_defs::*;
(
    input  logic [5:0]  i_opcode,
    input  logic [5:0]  i_funct,
    output instr_cls_t  o_cls,
    output logic [1:0]  o_ext_op,
    output logic        o_illegal
);

    always_comb begin
        o_cls = C_ILLEGAL;
        unique case (i_opcode)
            c_op_rtype: begin
                if (i_funct == c_fn_addu)      o_cls = C_ADDU;
                else if (i_funct == c_fn_subu) o_cls = C_SUBU;
                else                           o_cls = C_ILLEGAL;
            end
            c_op_ori: o_cls = C_ORI;
            c_op_lui: o_cls = C_LUI;
            c_op_lw:  o_cls = C_LW;
            c_op_sw:  o_cls = C_SW;
            c_op_beq: o_cls = C_BEQ;
            c_op_j:   o_cls = C_J;
            default:  o_cls = C_ILLEGAL;
        endcase
    end

    // Extender control is a pure opcode function so the datapath sees a
    // stable value in every state, including FETCH.
    always_comb begin
        o_ext_op = c_ext_none;
        case (i_opcode)
            c_op_ori:                    o_ext_op = c_ext_zero;
            c_op_lw, c_op_sw, c_op_beq:  o_ext_op = c_ext_sign;
            c_op_lui:                    o_ext_op = c_ext_lui;
            default:                     o_ext_op = c_ext_none;
        endcase
    end

    assign o_illegal = (o_cls == C_ILLEGAL);

endmodule : mips_mc_decode
`default_nettype wire

// File: rtl/mips_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mips_mc_ctrl
// Description : Multicycle MIPS control FSM. Sequences FETCH / DECODE / EXE /
//               MEM / WB for one instruction at a time, drives datapath
//               selects and handshakes with memory, with a wait-cycle
//               timeout on memory requests.
// Parameters  : MEM_TIMEOUT  max wait cycles in FETCH/MEM (0 = no timeout)
//               TO_W         wait counter width, MEM_TIMEOUT < 2**TO_W
// Ports       : clk, rst (async, active-high)
//               opcode/funct/zero/mem_ready  - inputs from IR, ALU, memory
//               mem_req/mem_we               - memory request
//               ir_we/pc_we/pc_src           - IR and PC update
//               ext_op/alu_op/alu_src_b      - extender and ALU control
//               rf_we/rf_dst/rf_wsel         - register-file write control
//               illegal/bus_err              - 1-cycle error pulses
//               state_o                      - current state (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module mips_mc_ctrl
    import mips_defs::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic [1:0]  ext_op,
    output logic [1:0]  alu_op,
    output logic        alu_src_b,
    output logic        rf_we,
    output logic        rf_dst,
    output logic        rf_wsel,
    output logic        illegal,
    output logic        bus_err,
    output logic [2:0]  state_o
);

    localparam logic [TO_W-1:0] c_cnt_last = TO_W'(MEM_TIMEOUT - 1);
    localparam logic [TO_W-1:0] c_cnt_one  = TO_W'(1);

    state_t          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;

    instr_cls_t      w_cls;
    logic [1:0]      w_ext_op;
    logic            w_illegal;
    logic            w_timeout;

    // Ungated output values; forced to zero during reset below.
    logic            w_mem_req, w_mem_we, w_ir_we, w_pc_we;
    logic [1:0]      w_pc_src, w_alu_op;
    logic            w_alu_src_b, w_rf_we, w_rf_dst, w_rf_wsel;
    logic            w_illegal_p, w_bus_err;

    mips_mc_decode u_decode (
        .i_opcode  (opcode),
        .i_funct   (funct),
        .o_cls     (w_cls),
        .o_ext_op  (w_ext_op),
        .o_illegal (w_illegal)
    );

    // Last permitted wait cycle with no completion; mem_ready on this same
    // cycle takes priority and completes normally.
    assign w_timeout = (MEM_TIMEOUT != 0) && (cnt_q == c_cnt_last) && !mem_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;       // counter is nonzero only while waiting
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        w_ir_we     = 1'b0;
        w_pc_we     = 1'b0;
        w_pc_src    = c_pc_plus4;
        w_alu_op    = c_alu_add;
        w_alu_src_b = 1'b0;
        w_rf_we     = 1'b0;
        w_rf_dst    = 1'b0;
        w_rf_wsel   = 1'b0;
        w_illegal_p = 1'b0;
        w_bus_err   = 1'b0;

        case (state_q)
            S_FETCH: begin
                w_mem_req = 1'b1;
                if (mem_ready) begin
                    w_ir_we  = 1'b1;
                    w_pc_we  = 1'b1;
                    w_pc_src = c_pc_plus4;
                    state_d  = S_DECODE;
                end else if (w_timeout) begin
                    // PC untouched, so the refetch targets the same address.
                    w_bus_err = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end

            S_DECODE: begin
                if (w_illegal) begin
                    w_illegal_p = 1'b1;
                    state_d     = S_FETCH;
                end else if (w_cls == C_J) begin
                    w_pc_we  = 1'b1;
                    w_pc_src = c_pc_jump;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_EXE;
                end
            end

            S_EXE: begin
                case (w_cls)
                    C_ADDU: begin
                        w_alu_op = c_alu_add;
                        state_d  = S_WB;
                    end
                    C_SUBU: begin
                        w_alu_op = c_alu_sub;
                        state_d  = S_WB;
                    end
                    C_ORI: begin
                        w_alu_op    = c_alu_or;
                        w_alu_src_b = 1'b1;
                        state_d     = S_WB;
                    end
                    C_LUI: begin
                        w_alu_op    = c_alu_pass;
                        w_alu_src_b = 1'b1;
                        state_d     = S_WB;
                    end
                    C_LW, C_SW: begin
                        w_alu_op    = c_alu_add;
                        w_alu_src_b = 1'b1;
                        state_d     = S_MEM;
                    end
                    C_BEQ: begin
                        w_alu_op = c_alu_sub;
                        w_pc_we  = zero;
                        w_pc_src = c_pc_branch;
                        state_d  = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end

            S_MEM: begin
                w_mem_req = 1'b1;
                w_mem_we  = (w_cls == C_SW);
                if (mem_ready) begin
                    state_d = (w_cls == C_LW) ? S_WB : S_FETCH;
                end else if (w_timeout) begin
                    w_bus_err = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end

            S_WB: begin
                w_rf_we   = 1'b1;
                w_rf_dst  = (w_cls == C_ADDU) || (w_cls == C_SUBU);
                w_rf_wsel = (w_cls == C_LW);
                state_d   = S_FETCH;
            end

            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset gates every output so an aborted instruction cannot leave a
    // partial write behind.
    assign mem_req   = w_mem_req   & ~rst;
    assign mem_we    = w_mem_we    & ~rst;
    assign ir_we     = w_ir_we     & ~rst;
    assign pc_we     = w_pc_we     & ~rst;
    assign pc_src    = w_pc_src    & {2{~rst}};
    assign ext_op    = w_ext_op    & {2{~rst}};
    assign alu_op    = w_alu_op    & {2{~rst}};
    assign alu_src_b = w_alu_src_b & ~rst;
    assign rf_we     = w_rf_we     & ~rst;
    assign rf_dst    = w_rf_dst    & ~rst;
    assign rf_wsel   = w_rf_wsel   & ~rst;
    assign illegal   = w_illegal_p & ~rst;
    assign bus_err   = w_bus_err   & ~rst;
    assign state_o   = state_q     & {3{~rst}};

endmodule : mips_mc_ctrl
`default_nettype wire
